// File: rtl/slc3_pkg.sv
// Shared SLC3 datapath types and constants used by the sequential multiplier.
package slc3_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_W     = 16;
  localparam int MULT_ITERS = 16;

endpackage

// File: rtl/adder_16.sv
// 16-bit ripple-style adder with carry-in and carry-out.
module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/mult_seq_16.sv
// Sequential 16x16 unsigned shift-add multiplier; one add/shift per clock,
// valid/ready handshakes on operands and product.
module mult_seq_16
  import slc3_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH != MULT_W) begin : g_width_check
    $error("mult_seq_16: WIDTH must be 16 to match adder_16");
  end

  mult_state_t      state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [3:0]       cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign addend = q[0] ? m : '0;

  adder_16 u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, keeping the {acc,q} shift order-independent.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= mcand;
            q     <= mplier;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Carry-out lands in acc MSB; the 33-bit value shifts right by one.
          {acc, q} <= {carry, sum, q[WIDTH-1:1]};
          cnt      <= cnt + 4'd1;
          if (cnt == 4'(MULT_ITERS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {acc, q};

endmodule

// File: tb/tb_mult_seq_16.sv
// Self-checking bench for mult_seq_16: directed cases plus a randomized
// back-to-back stream scored against a plain-arithmetic product model.
module tb_mult_seq_16;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  mult_seq_16 dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mcand     (mcand),
    .mplier    (mplier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wa, wb;
    wa = {16'h0, a};
    wb = {16'h0, b};
    return wa * wb;
  endfunction

  // Presents operands for one accept edge; returns at the negedge after it.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit keep_valid);
    @(negedge Clk);
    check({tag, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    mcand    = a;
    mplier   = b;
    @(negedge Clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, then checks latency and product.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
      if (out_valid !== 1'b1)
        check({tag, " in_ready while busy"}, {31'b0, in_ready}, 32'd0);
    end
    check({tag, " latency"}, n, 32'd16);
    check({tag, " product"}, product, exp);
  endtask

  logic [31:0] exp_q[$];
  int          accepted;
  int          received;
  int          cyc;
  logic [31:0] held;

  initial begin
    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mcand     = '0;
    mplier    = '0;
    #12;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset product", product, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Basic multiply with out_ready already high.
    out_ready = 1'b1;
    start_op("basic", 16'h0003, 16'h0005, 1'b0);
    wait_done("basic", 32'h0000_000F);
    @(negedge Clk);
    check("basic in_ready after handshake", {31'b0, in_ready}, 32'd1);
    check("basic out_valid after handshake", {31'b0, out_valid}, 32'd0);

    // Carry-out captured every iteration.
    start_op("carry", 16'hFFFF, 16'hFFFF, 1'b0);
    wait_done("carry", 32'hFFFE_0001);
    @(negedge Clk);

    // Zero multiplicand still runs the full 16 cycles.
    start_op("zero", 16'h0000, 16'h1234, 1'b0);
    wait_done("zero", 32'h0000_0000);
    @(negedge Clk);

    // Held output while consumer stalls.
    out_ready = 1'b0;
    start_op("hold", 16'h8000, 16'h0002, 1'b0);
    wait_done("hold", 32'h0001_0000);
    held = product;
    repeat (5) begin
      @(negedge Clk);
      check("hold out_valid", {31'b0, out_valid}, 32'd1);
      check("hold product stable", product, 32'h0001_0000);
      check("hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    check("hold product vs first", product, held);
    out_ready = 1'b1;
    @(negedge Clk);
    check("hold released in_ready", {31'b0, in_ready}, 32'd1);

    // Busy rejection: a different operand pair is presented throughout RUN.
    start_op("busy", 16'h1234, 16'h0010, 1'b1);
    mcand  = 16'h00FF;
    mplier = 16'h0101;
    wait_done("busy", 32'h0001_2340);
    in_valid = 1'b0;
    @(negedge Clk);

    // Asynchronous reset partway through.
    start_op("rst", 16'h1234, 16'h5678, 1'b0);
    repeat (7) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst product", product, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    start_op("after rst", 16'h0007, 16'h0009, 1'b0);
    wait_done("after rst", 32'h0000_003F);
    @(negedge Clk);

    // Randomized back-to-back stream with a FIFO scoreboard.
    accepted = 0;
    received = 0;
    cyc      = 0;
    while ((accepted < 200 || received < accepted) && cyc < 20000) begin
      @(negedge Clk);
      cyc++;
      if (out_valid && in_ready)
        check("rand exclusive ready/valid", 32'd1, 32'd0);
      out_ready = ($urandom_range(0, 1) == 1);
      if (accepted < 200) begin
        in_valid = ($urandom_range(0, 3) != 0);
        mcand    = 16'($urandom);
        mplier   = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand unexpected product", product, 32'hDEAD_BEEF);
        end else begin
          check("rand product", product, exp_q.pop_front());
        end
        received++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(ref_mul(mcand, mplier));
        accepted++;
      end
    end
    check("rand completed in budget", {31'b0, cyc < 20000}, 32'd1);
    check("rand received count", received, 32'd200);
    check("rand scoreboard empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
